// File: rtl/io_pkg.sv
// Shared IO-block constants: switch width, read offsets, default debounce length.
// Latency: none (constants only).
// Backpressure: none.
package io_pkg;
    localparam int         SW_W                = 4;
    localparam logic [1:0] SW_OFF_VALUE        = 2'b00;
    localparam logic [1:0] SW_OFF_STATUS       = 2'b01;
    localparam int         DEBOUNCE_CYCLES_DEF = 1_000_000;
endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous inputs.
// Latency: 2 clock edges from d_i to q_o.
// Backpressure: none; samples on every edge.
module bit_sync2 #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    // Metastability chain: first flop may go metastable, second settles it.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/switch_reader.sv
// Switch input stage: sync + debounce board switches, expose value and sticky
// changed flag on the IO read path. Build option: SWITCH_DEBOUNCE_EN.
// Latency: read data combinational; pin-to-stable 2+DEBOUNCE_CYCLES edges (3 without debounce). No backpressure.
module switch_reader
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [SW_W-1:0] switch_in,
    input  logic            ioRead,
    input  logic            switchCtrl,
    input  logic [1:0]      addr_low,
    output logic [SW_W-1:0] io_rdata
);
    logic [SW_W-1:0] sync2;
    logic [SW_W-1:0] stable_q;
    logic [SW_W-1:0] stable_d;
    logic            changed_q;
    logic            changed_d;
    logic            set_chg;
    logic            rd;
    logic            rd_value;
    logic            rd_status;

    bit_sync2 #(.W(SW_W)) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (switch_in),
        .q_o   (sync2)
    );

    assign rd        = ioRead & switchCtrl;
    assign rd_value  = rd && (addr_low == SW_OFF_VALUE);
    assign rd_status = rd && (addr_low == SW_OFF_STATUS);

`ifdef SWITCH_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [SW_W-1:0]  cand_q;
    logic [SW_W-1:0]  cand_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Debounce: a new value must hold for DEBOUNCE_CYCLES edges; any bounce restarts the count.
    always_comb begin
        stable_d = stable_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        set_chg  = 1'b0;
        if (sync2 == stable_q) begin
            cand_d = stable_q;
            cnt_d  = '0;
        end else if (sync2 != cand_q) begin
            cand_d = sync2;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = cand_q;
            cnt_d    = '0;
            set_chg  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Candidate tracking state.
    always_ff @(posedge clock) begin
        if (reset) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    // The debounce length has no meaning in this build.
    logic unused_cfg;
    assign unused_cfg = (DEBOUNCE_CYCLES > 1);

    // No debounce: stable simply follows the synchronized pins.
    always_comb begin
        stable_d = sync2;
        set_chg  = (sync2 != stable_q);
    end
`endif

    // Sticky flag: a set on the same edge as a status read wins over the clear.
    assign changed_d = set_chg | (changed_q & ~rd_status);

    // Accepted switch value and changed flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            stable_q  <= stable_d;
            changed_q <= changed_d;
        end
    end

    // Read mux: zero-latency, zero for unselected or unmapped offsets.
    always_comb begin
        io_rdata = '0;
        if (rd_value) begin
            io_rdata = stable_q;
        end else if (rd_status) begin
            io_rdata = {{(SW_W-1){1'b0}}, changed_q};
        end
    end
endmodule

// File: tb/tb_switch_reader.sv
module tb_switch_reader;
    localparam int D = 8;
`ifdef SWITCH_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = D + 2;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 3;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] switch_in;
    logic       ioRead;
    logic       switchCtrl;
    logic [1:0] addr_low;
    logic [3:0] io_rdata;

    int errors = 0;
    int checks = 0;

    switch_reader #(.DEBOUNCE_CYCLES(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .switch_in  (switch_in),
        .ioRead     (ioRead),
        .switchCtrl (switchCtrl),
        .addr_low   (addr_low),
        .io_rdata   (io_rdata)
    );

    always #5 clock = ~clock;

    // Reference model: pin history, accepted value, sticky flag, and the
    // length of the current run of identical synchronized samples.
    logic [3:0] m_p1 = '0, m_p2 = '0, m_stable = '0, m_run_val = '0;
    logic       m_changed = 1'b0;
    int         m_run_len = 0;
    bit         m_valid = 1'b0;

    function automatic logic [3:0] model_rdata(input logic rd, input logic [1:0] a);
        if (rd && a == 2'b00) return m_stable;
        if (rd && a == 2'b01) return {3'b000, m_changed};
        return 4'h0;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] sw, input logic clr);
        logic [3:0] s2;
        logic       set;
        if (r) begin
            m_p1 = '0; m_p2 = '0; m_stable = '0; m_changed = 1'b0;
            m_run_val = '0; m_run_len = 0;
        end else begin
            s2  = m_p2;
            set = 1'b0;
            if (DEB) begin
                if (m_run_len > 0 && s2 == m_run_val) m_run_len++;
                else begin
                    m_run_val = s2;
                    m_run_len = 1;
                end
                if (s2 != m_stable && m_run_len >= D) begin
                    m_stable = s2;
                    set = 1'b1;
                end
            end else begin
                set = (s2 != m_stable);
                m_stable = s2;
            end
            m_changed = set | (m_changed & ~clr);
            m_p2 = m_p1;
            m_p1 = sw;
        end
    endtask

    task automatic compare(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: io_rdata=%h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check read data before the edge, advance model.
    task automatic step(input logic r, input logic [3:0] sw, input logic ior, input logic sc,
                        input logic [1:0] a, input bit use_exp, input logic [3:0] exp,
                        input string name);
        reset = r; switch_in = sw; ioRead = ior; switchCtrl = sc; addr_low = a;
        #1;
        if (m_valid) compare({name, "/model"}, io_rdata, model_rdata(ior & sc, a));
        if (use_exp) compare(name, io_rdata, exp);
        @(posedge clock);
        model_edge(r, sw, ior & sc & (a == 2'b01));
        m_valid = 1'b1;
        @(negedge clock);
    endtask

    typedef struct {
        logic       ior;
        logic       sc;
        logic [1:0] a;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 2'b00, 4'hA, "dec_value"};
        vecs[1] = '{1'b0, 1'b1, 2'b00, 4'h0, "dec_rd_low"};
        vecs[2] = '{1'b1, 1'b0, 2'b00, 4'h0, "dec_cs_low"};
        vecs[3] = '{1'b1, 1'b1, 2'b10, 4'h0, "dec_off2"};
        vecs[4] = '{1'b1, 1'b1, 2'b11, 4'h0, "dec_off3"};
        vecs[5] = '{1'b1, 1'b0, 2'b01, 4'h0, "dec_stat_cs_low"};
        vecs[6] = '{1'b1, 1'b1, 2'b01, 4'h1, "dec_stat_set"};
        vecs[7] = '{1'b1, 1'b1, 2'b01, 4'h0, "dec_stat_cleared"};
        vecs[8] = '{1'b1, 1'b1, 2'b00, 4'hA, "dec_value_again"};

        reset = 1'b1; switch_in = 4'hF; ioRead = 1'b0; switchCtrl = 1'b0; addr_low = 2'b00;
        @(negedge clock);

        // Reset held with pins high: reads return 0.
        for (int k = 0; k < 3; k++) step(1'b1, 4'hF, 1'b1, 1'b1, 2'b00, k > 0, 4'h0, "rst_value");
        step(1'b1, 4'hF, 1'b1, 1'b1, 2'b01, 1'b1, 4'h0, "rst_status");
        // Release with pins held: stable appears after edge LAT.
        for (int k = 0; k <= LAT + 1; k++)
            step(1'b0, 4'hF, 1'b1, 1'b1, 2'b00, 1'b1, (k >= LAT) ? 4'hF : 4'h0, "rel_value");
        step(1'b0, 4'hF, 1'b1, 1'b1, 2'b01, 1'b1, 4'h1, "rel_status");
        step(1'b0, 4'hF, 1'b1, 1'b1, 2'b01, 1'b1, 4'h0, "rel_status_clr");

        // Status read on the acceptance edge: set wins.
        for (int k = 0; k <= LAT + 1; k++) begin
            if (k == LAT - 1)
                step(1'b0, 4'h0, 1'b1, 1'b1, 2'b01, 1'b1, 4'h0, "same_edge_rd");
            else if (k >= LAT)
                step(1'b0, 4'h0, 1'b1, 1'b1, 2'b01, 1'b1, (k == LAT) ? 4'h1 : 4'h0, "same_edge_after");
            else
                step(1'b0, 4'h0, 1'b1, 1'b1, 2'b00, 1'b1, 4'hF, "same_edge_old");
        end

        // Step 0 -> 5: value 0 through edge LAT-1, 5 from edge LAT.
        for (int k = 0; k <= LAT + 2; k++)
            step(1'b0, 4'h5, 1'b1, 1'b1, 2'b00, 1'b1, (k >= LAT) ? 4'h5 : 4'h0, "latency");
        step(1'b0, 4'h5, 1'b1, 1'b1, 2'b01, 1'b1, 4'h1, "latency_status");

        // Back to 0, then bounce 5,5,5,0,5...: accepted LAT edges after last transition.
        for (int k = 0; k < 20; k++) step(1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, "settle0");
        step(1'b0, 4'h0, 1'b1, 1'b1, 2'b01, 1'b0, 4'h0, "settle0_clr");
        for (int k = 0; k <= 16; k++) begin
            logic [3:0] p;
            p = (k == 3) ? 4'h0 : 4'h5;
            if (k == 13 || k == 15)
                step(1'b0, p, 1'b1, 1'b1, 2'b01, DEB, (k == 15) ? 4'h1 : 4'h0, "bounce_status");
            else
                step(1'b0, p, 1'b1, 1'b1, 2'b00, DEB, (k >= 4 + LAT) ? 4'h5 : 4'h0, "bounce_value");
        end

        // Decode table with stable=A and changed freshly set.
        for (int k = 0; k < 20; k++) step(1'b0, 4'hA, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, "settleA");
        foreach (vecs[i])
            step(1'b0, 4'hA, vecs[i].ior, vecs[i].sc, vecs[i].a, 1'b1, vecs[i].exp, vecs[i].name);

        // Reset mid-debounce (cnt=5): candidate discarded, stable stays 0.
        step(1'b1, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, "abort_rst");
        for (int k = 0; k < 7; k++) step(1'b0, 4'h3, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, "abort_pre");
        step(1'b1, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, "abort_hit");
        for (int k = 0; k < 15; k++) step(1'b0, 4'h0, 1'b1, 1'b1, 2'b00, DEB, 4'h0, "abort_value");
        step(1'b0, 4'h0, 1'b1, 1'b1, 2'b01, DEB, 4'h0, "abort_status");

        // Randomized: runs of random pin values, random reads, rare resets.
        begin
            logic [3:0] p;
            int hold;
            p = 4'h0; hold = 0;
            for (int n = 0; n < 1500; n++) begin
                if (hold == 0) begin
                    p = 4'($urandom_range(0, 15));
                    hold = $urandom_range(1, 12);
                end
                hold--;
                step(($urandom_range(0, 199) == 0), p, 1'($urandom), 1'($urandom),
                     2'($urandom), 1'b0, 4'h0, "random");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/switch_reader.md
# switch_reader

Switch input stage feeding the IO read-data path of the CPU's load mux. It synchronizes and debounces the four board switches and holds a clean stable value. On an IO load decoded to the switch chip select, it drives that value, or a sticky "changed" status bit, onto `io_rdata`; the load mux passes `io_rdata` to register write-back zero-extended to 32 bits.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000 — consecutive cycles a new synchronized value must persist before it is accepted; legal range ≥ 2.
- `CNT_W`, $clog2(DEBOUNCE_CYCLES) — debounce counter width; derived, never overridden.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `switch_in`  in  4  raw switch pins, asynchronous to `clock`.
- `ioRead`  in  1  IO read strobe from the Controller.
- `switchCtrl`  in  1  switch chip select from address decode, active high.
- `addr_low`  in  2  low address bits of the load.
- `io_rdata`  out  4  read data to the load mux.

## Operation
- The 2-flop synchronizer `sync1 → sync2` samples `switch_in` on each edge.
- Debounce registers: `stable[3:0]`, `cand[3:0]`, `cnt[CNT_W-1:0]`, `changed`. Each edge, in priority order:
  - `sync2 == stable`: `cand <= stable`, `cnt <= 0`.
  - `sync2 != cand`: `cand <= sync2`, `cnt <= 1`. This starts a new candidate and discards any bounce.
  - `cnt == DEBOUNCE_CYCLES-1`: `stable <= cand`, `cnt <= 0`, set `changed`.
  - otherwise: `cnt <= cnt + 1`.
- The counter never wraps. It is bounded by the accept step at `DEBOUNCE_CYCLES-1`.
- Read select is `rd = ioRead && switchCtrl`. The output is combinational:
  - `rd && addr_low==2'b00` → `io_rdata = stable`.
  - `rd && addr_low==2'b01` → `io_rdata = {3'b0, changed}`.
  - any other case, including `rd` low or `addr_low` of 2'b10 or 2'b11 → `io_rdata = 4'b0`.
- Read-to-clear: `changed` clears on the edge where `rd && addr_low==2'b01`.
- If a set and a clear occur on the same edge, the set wins and `changed` ends at 1.
- Reading `stable` has no side effects.

## Timing
- Reset values: `sync1`, `sync2`, `stable`, `cand` = 4'b0; `cnt` = 0; `changed` = 0. `io_rdata` = 0 while `rd` is low.
- Asserting `reset` mid-debounce aborts the count. No `changed` is raised for the aborted candidate.
- Debounce latency: if `switch_in` changes before edge 0 and then holds, `sync2` shows the new value after edge 2. `stable` updates and `changed` sets on edge 2+`DEBOUNCE_CYCLES`.
- Any `sync2` deviation before acceptance restarts the count from the deviation edge.
- If the switches return to the old `stable` value before acceptance, nothing updates and `changed` is not set.
- Read data is valid in the same cycle as `rd`, with zero added latency. `changed` is the only state altered by a read, and it changes on that cycle's edge.

## Configuration
- `SWITCH_DEBOUNCE_EN` defined: the debounce logic operates as described in Operation.
- `SWITCH_DEBOUNCE_EN` undefined:
  - `cand` and `cnt` are not instantiated.
  - `stable <= sync2` on every edge.
  - `changed` sets whenever `sync2 != stable`.
  - Latency from pin change to `stable` is 3 edges.
  - `DEBOUNCE_CYCLES` is ignored.

## Structure
- Shared package `io_pkg` holds:
  - `SW_W = 4`.
  - `SW_OFF_VALUE = 2'b00` and `SW_OFF_STATUS = 2'b01`.
  - Default `DEBOUNCE_CYCLES`.
- One sub-module, `bit_sync2`: a parameterized-width 2-flop synchronizer with synchronous reset, instantiated once at width `SW_W`.
- The debounce logic and read decode live in `switch_reader`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=8`.
- Reset with `switch_in=4'hF` held → all outputs 0 during reset. After release, with pins held, `stable=4'hF` on edge 10 and `changed=1`.
- Step `switch_in` 0→4'h5 at edge 0, then hold → `rd`/`addr_low=00` returns 4'h0 through edge 9 and 4'h5 from edge 10.
- Bounce: 4'h5 for 3 cycles, 4'h0 for 1, then 4'h5 held → accepted 8 cycles after the last transition reaches `sync2`. No intermediate `changed`.
- Status read with `changed=1` → `io_rdata=4'h1` that cycle; a read the next cycle returns 4'h0. Status read on the same edge as acceptance → `changed` remains 1.
- `rd` low, or `addr_low=2'b10` → `io_rdata=4'h0` regardless of `stable`. `ioRead=1` with `switchCtrl=0` → 4'h0 and `changed` unaffected.
- `reset` asserted at `cnt=5` → the candidate is discarded and `stable` stays 0. Build without `SWITCH_DEBOUNCE_EN` → a step is visible on edge 3.
